// File: rtl/cpu_stack_ctl_pkg.sv
// Shared constants and types for the operand-stack controller.
//   STK_DATA_W : tagged stack word width ({type, 32b value})
//   STK_POP_W  : width of the stage-4 pop count
//   stk_state_e: spill/fill FSM states
package cpu_stack_ctl_pkg;
  localparam int STK_DATA_W = 35;
  localparam int STK_POP_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL_RD  = 2'd1,
    S_FILL_CAP = 2'd2
  } stk_state_e;
endpackage

// File: rtl/cpu_stack_ram.sv
// 1RW synchronous stack RAM, 2**ADDR_W x DATA_W, one-cycle read latency.
//   clk               : clock
//   i_we / i_re       : write / read strobes (never both)
//   i_addr, i_wdata   : address, write data
//   o_rdata           : read data, valid the cycle after i_re
module cpu_stack_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 35
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/cpu_stack_ctl.sv
// Operand-stack controller. Applies each stage-4 pop/push pair, caching the
// top two entries (TOS/NOS) in flops and spilling/filling deeper entries to
// an external 1RW RAM. Stalls upstream while the cache is being refilled.
//   clk, rst_b        : clock, async active-low reset
//   st__valid_4a      : stage-4 op present
//   st__to_pop_4a     : entries to pop (applied first)
//   st__push_4a/_to_push_4a : push one word after the pop
//   st__stall         : op not accepted this cycle
//   st__tos/st__nos   : cached top / next entries
//   st__depth         : total entries (RAM + cache)
//   st__err_under/over: sticky underflow / overflow flags
//   ram_*             : external stack RAM port
module cpu_stack_ctl
  import cpu_stack_ctl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = STK_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 st__valid_4a,
  input  logic [STK_POP_W-1:0] st__to_pop_4a,
  input  logic                 st__push_4a,
  input  logic [DATA_W-1:0]    st__to_push_4a,
  output logic                 st__stall,
  output logic [DATA_W-1:0]    st__tos,
  output logic [DATA_W-1:0]    st__nos,
  output logic [ADDR_W+1:0]    st__depth,
  output logic                 st__err_under,
  output logic                 st__err_over,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic                 ram_re,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);
  localparam int SP_W    = ADDR_W + 1;
  localparam int DEPTH_W = ADDR_W + 2;
  // compare width wide enough for both the pop count and the depth
  localparam int CW      = ((DEPTH_W > STK_POP_W) ? DEPTH_W : STK_POP_W) + 1;
  localparam logic [SP_W-1:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};

  stk_state_e        r_state, w_state_nxt;
  logic [SP_W-1:0]   r_sp;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_tos, r_nos;
  logic              r_err_under, r_err_over;

  logic              w_accept, w_under, w_over, w_spill, w_we, w_re;
  logic [DEPTH_W-1:0] w_depth;
  logic [CW-1:0]     w_pop_c, w_cnt_c, w_depth_c;
  logic [SP_W-1:0]   w_p_sp, w_n_sp, w_f_sp;
  logic [1:0]        w_p_cnt, w_n_cnt, w_f_cnt;
  logic [DATA_W-1:0] w_p_tos, w_p_nos, w_n_tos, w_n_nos;

  // gating with rst_b keeps the RAM strobes quiet while reset is held
  assign w_accept  = rst_b & (r_state == S_IDLE) & st__valid_4a;
  assign w_depth   = DEPTH_W'(r_sp) + DEPTH_W'(r_cnt);
  assign w_pop_c   = CW'(st__to_pop_4a);
  assign w_cnt_c   = CW'(r_cnt);
  assign w_depth_c = CW'(w_depth);

  // pop then push, evaluated against the current cache
  always_comb begin
    w_p_sp  = r_sp;
    w_p_cnt = r_cnt;
    w_p_tos = r_tos;
    w_p_nos = r_nos;
    w_under = 1'b0;
    if (w_pop_c <= w_cnt_c) begin
      if (st__to_pop_4a[1:0] == 2'd1) begin
        w_p_tos = r_nos;
        w_p_nos = '0;
        w_p_cnt = r_cnt - 2'd1;
      end else if (st__to_pop_4a[1:0] == 2'd2) begin
        w_p_tos = '0;
        w_p_nos = '0;
        w_p_cnt = 2'd0;
      end
    end else if (w_pop_c <= w_depth_c) begin
      w_p_sp  = r_sp - SP_W'(w_pop_c - w_cnt_c);
      w_p_cnt = 2'd0;
      w_p_tos = '0;
      w_p_nos = '0;
    end else begin
      w_under = 1'b1;
      w_p_sp  = '0;
      w_p_cnt = 2'd0;
      w_p_tos = '0;
      w_p_nos = '0;
    end

    w_n_sp  = w_p_sp;
    w_n_cnt = w_p_cnt;
    w_n_tos = w_p_tos;
    w_n_nos = w_p_nos;
    w_spill = 1'b0;
    w_over  = 1'b0;
    if (st__push_4a) begin
      if (w_p_cnt < 2'd2) begin
        w_n_nos = w_p_tos;
        w_n_tos = st__to_push_4a;
        w_n_cnt = w_p_cnt + 2'd1;
      end else if (w_p_sp == SP_FULL) begin
        w_over = 1'b1;               // push dropped, nothing moves
      end else begin
        w_spill = 1'b1;              // NOS goes to RAM at sp this cycle
        w_n_sp  = w_p_sp + SP_W'(1);
        w_n_nos = w_p_tos;
        w_n_tos = st__to_push_4a;
      end
    end
  end

  // fill FSM
  always_comb begin
    w_state_nxt = r_state;
    w_f_sp      = r_sp - SP_W'(1);
    w_f_cnt     = r_cnt + 2'd1;
    case (r_state)
      S_IDLE:     if (w_accept && w_n_cnt < 2'd2 && w_n_sp != '0) w_state_nxt = S_FILL_RD;
      S_FILL_RD:  w_state_nxt = S_FILL_CAP;
      S_FILL_CAP: w_state_nxt = (w_f_cnt < 2'd2 && w_f_sp != '0) ? S_FILL_RD : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_sp        <= '0;
      r_cnt       <= 2'd0;
      r_tos       <= '0;
      r_nos       <= '0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sp        <= w_n_sp;
        r_cnt       <= w_n_cnt;
        r_tos       <= w_n_tos;
        r_nos       <= w_n_nos;
        r_err_under <= r_err_under | w_under;
        r_err_over  <= r_err_over | w_over;
      end else if (r_state == S_FILL_CAP) begin
        // fill the lowest empty slot
        if (r_cnt == 2'd0) r_tos <= ram_rdata;
        else               r_nos <= ram_rdata;
        r_sp  <= w_f_sp;
        r_cnt <= w_f_cnt;
      end
    end
  end

  assign w_we = w_accept & w_spill;
  assign w_re = (r_state == S_FILL_RD);

  assign st__stall     = (r_state != S_IDLE);
  assign st__tos       = r_tos;
  assign st__nos       = r_nos;
  assign st__depth     = w_depth;
  assign st__err_under = r_err_under;
  assign st__err_over  = r_err_over;
  assign ram_we        = w_we;
  assign ram_re        = w_re;
  assign ram_wdata     = w_we ? r_nos : '0;
  // sp is in 1..2**ADDR_W during a fill, so the low bits minus one is sp-1
  assign ram_addr      = w_we ? r_sp[ADDR_W-1:0]
                       : (w_re ? r_sp[ADDR_W-1:0] - ADDR_W'(1) : '0);
endmodule

// File: tb/tb_cpu_stack_ctl.sv
module tb_cpu_stack_ctl;
  localparam int AW = 2;
  localparam int DW = 35;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          valid, push;
  logic [10:0]   pop;
  logic [DW-1:0] word;
  logic          stall, eu, eo, we, re;
  logic [DW-1:0] tos, nos, wdata, rdata;
  logic [AW+1:0] depth;
  logic [AW-1:0] addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_stack_ctl #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .st__valid_4a(valid), .st__to_pop_4a(pop), .st__push_4a(push),
    .st__to_push_4a(word), .st__stall(stall), .st__tos(tos), .st__nos(nos),
    .st__depth(depth), .st__err_under(eu), .st__err_over(eo),
    .ram_addr(addr), .ram_we(we), .ram_re(re), .ram_wdata(wdata),
    .ram_rdata(rdata)
  );

  cpu_stack_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk(clk), .i_we(we), .i_re(re), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata)
  );

  typedef struct {
    logic          vld;
    logic [10:0]   pop;
    logic          push;
    logic [DW-1:0] word;
    logic          stall, we, re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, tos, nos;
    logic [AW+1:0] depth;
    logic          eu, eo;
  } vec_t;

  vec_t tab[$];

  localparam logic [DW-1:0] A = 35'h4_0000_000A, B = 35'h2_0000_000B,
                            C = 35'h1_0000_000C, D = 35'h3_0000_000D,
                            E = 35'h5_0000_000E, F = 35'h6_0000_000F,
                            G = 35'h7_0000_0010, X = 35'h0_DEAD_BEEF,
                            Y = 35'h2_1234_5678;

  task automatic chk(input string nm, input int row, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, got, exp);
    end
  endtask

  function automatic void add(input logic v, input int p, input logic ps, input logic [DW-1:0] w,
                              input logic st, input logic e_we, input logic e_re, input int e_addr,
                              input logic [DW-1:0] e_wd, input logic [DW-1:0] e_tos,
                              input logic [DW-1:0] e_nos, input int e_d, input logic e_eu,
                              input logic e_eo);
    vec_t t;
    t.vld = v; t.pop = 11'(p); t.push = ps; t.word = w;
    t.stall = st; t.we = e_we; t.re = e_re; t.addr = AW'(e_addr);
    t.wd = e_wd; t.tos = e_tos; t.nos = e_nos; t.depth = (AW+2)'(e_d);
    t.eu = e_eu; t.eo = e_eo;
    tab.push_back(t);
  endfunction

  task automatic drive(input logic v, input int p, input logic ps, input logic [DW-1:0] w);
    valid = v; pop = 11'(p); push = ps; word = w;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall"}, -1, 64'(stall), 64'd0);
    chk({tag, " tos"},   -1, 64'(tos),   64'd0);
    chk({tag, " nos"},   -1, 64'(nos),   64'd0);
    chk({tag, " depth"}, -1, 64'(depth), 64'd0);
    chk({tag, " eu"},    -1, 64'(eu),    64'd0);
    chk({tag, " eo"},    -1, 64'(eo),    64'd0);
    chk({tag, " we"},    -1, 64'(we),    64'd0);
    chk({tag, " re"},    -1, 64'(re),    64'd0);
    chk({tag, " addr"},  -1, 64'(addr),  64'd0);
    chk({tag, " wdata"}, -1, 64'(wdata), 64'd0);
  endtask

  initial begin
    // each row: inputs for one cycle, outputs expected during that cycle
    //   v  pop ps word  stall we re addr wd tos nos depth eu eo
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, '0, '0, 0, 0, 0);   // 0 idle
    add(1, 0, 1, A,  0, 0, 0, 0, '0, '0, '0, 0, 0, 0);   // 1 push A
    add(1, 0, 1, B,  0, 0, 0, 0, '0, A,  '0, 1, 0, 0);   // 2 push B
    add(1, 0, 1, C,  0, 1, 0, 0, A,  B,  A,  2, 0, 0);   // 3 push C spills A
    add(1, 0, 1, D,  0, 1, 0, 1, B,  C,  B,  3, 0, 0);   // 4 push D spills B
    add(1, 0, 1, E,  0, 1, 0, 2, C,  D,  C,  4, 0, 0);   // 5 push E spills C
    add(1, 2, 0, '0, 0, 0, 0, 0, '0, E,  D,  5, 0, 0);   // 6 pop 2
    add(0, 0, 0, '0, 1, 0, 1, 2, '0, '0, '0, 3, 0, 0);   // 7 FILL_RD addr 2
    add(0, 0, 0, '0, 1, 0, 0, 0, '0, '0, '0, 3, 0, 0);   // 8 FILL_CAP
    add(0, 0, 0, '0, 1, 0, 1, 1, '0, C,  '0, 3, 0, 0);   // 9 FILL_RD addr 1
    add(0, 0, 0, '0, 1, 0, 0, 0, '0, C,  '0, 3, 0, 0);   // 10 FILL_CAP
    add(1, 1, 1, X,  0, 0, 0, 0, '0, C,  B,  3, 0, 0);   // 11 pop1+push X
    add(1, 5, 0, '0, 0, 0, 0, 0, '0, X,  B,  3, 0, 0);   // 12 pop 5 underflows
    add(1, 0, 1, A,  0, 0, 0, 0, '0, '0, '0, 0, 1, 0);   // 13 push A
    add(1, 0, 1, B,  0, 0, 0, 0, '0, A,  '0, 1, 1, 0);   // 14 push B
    add(1, 1, 1, X,  0, 0, 0, 0, '0, B,  A,  2, 1, 0);   // 15 pop1+push X, depth 2
    add(1, 0, 1, C,  0, 1, 0, 0, A,  X,  A,  2, 1, 0);   // 16 spill A @0
    add(1, 0, 1, D,  0, 1, 0, 1, X,  C,  X,  3, 1, 0);   // 17 spill X @1
    add(1, 0, 1, E,  0, 1, 0, 2, C,  D,  C,  4, 1, 0);   // 18 spill C @2
    add(1, 0, 1, F,  0, 1, 0, 3, D,  E,  D,  5, 1, 0);   // 19 spill D @3 (RAM full)
    add(1, 0, 1, G,  0, 0, 0, 0, '0, F,  E,  6, 1, 0);   // 20 7th word overflows
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, F,  E,  6, 1, 1);   // 21 dropped push

    rst_b = 1'b0;
    drive(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      drive(tab[i].vld, int'(tab[i].pop), tab[i].push, tab[i].word);
      @(negedge clk);
      chk("stall", i, 64'(stall), 64'(tab[i].stall));
      chk("we",    i, 64'(we),    64'(tab[i].we));
      chk("re",    i, 64'(re),    64'(tab[i].re));
      chk("addr",  i, 64'(addr),  64'(tab[i].addr));
      if (tab[i].we) chk("wdata", i, 64'(wdata), 64'(tab[i].wd));
      chk("tos",   i, 64'(tos),   64'(tab[i].tos));
      chk("nos",   i, 64'(nos),   64'(tab[i].nos));
      chk("depth", i, 64'(depth), 64'(tab[i].depth));
      chk("eu",    i, 64'(eu),    64'(tab[i].eu));
      chk("eo",    i, 64'(eo),    64'(tab[i].eo));
      @(posedge clk);
      #1;
    end

    // pop 2 from a full stack, then reset while the first fill captures
    drive(1, 2, 0, '0);
    @(negedge clk);
    chk("mid pop stall", 100, 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("mid rd stall", 101, 64'(stall), 64'd1);
    chk("mid rd re",    101, 64'(re),    64'd1);
    chk("mid rd addr",  101, 64'(addr),  64'd3);
    chk("mid rd depth", 101, 64'(depth), 64'd4);
    @(posedge clk);
    #1;
    chk("mid cap stall", 102, 64'(stall), 64'd1);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk_zero("async rst");
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    drive(1, 0, 1, Y);
    #1;
    chk("post rst stall", 103, 64'(stall), 64'd0);
    chk("post rst we",    103, 64'(we),    64'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, '0);
    @(negedge clk);
    chk("post rst tos",   104, 64'(tos),   64'(Y));
    chk("post rst nos",   104, 64'(nos),   64'd0);
    chk("post rst depth", 104, 64'(depth), 64'd1);
    chk("post rst stall", 104, 64'(stall), 64'd0);
    chk("post rst eu",    104, 64'(eu),    64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
